// File: rtl/tlul_host_port.sv
// TileLink-UL host port: one core load/store becomes one A-channel request and one D-channel response.
// Optional D-channel timeout and late-beat sink enabled by defining TLUL_PORT_TIMEOUT_EN.
module tlul_host_port #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [2:0]            a_opcode,
  output logic [1:0]            a_size,
  output logic [ADDR_W-1:0]     a_address,
  output logic [DATA_W/8-1:0]   a_mask,
  output logic [DATA_W-1:0]     a_data,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [2:0]            d_opcode,
  input  logic [DATA_W-1:0]     d_data,
  input  logic                  d_error
);

  localparam int STRB = DATA_W / 8;
  localparam int OFF  = $clog2(STRB);

`ifdef TLUL_PORT_TIMEOUT_EN
  localparam int   CNT_W     = (TIMEOUT_CYC < 256) ? 8 : 16;
  localparam logic IDLE_SINK = 1'b1;
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam logic IDLE_SINK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state;

  logic                we_q;
  logic                uns_q;
  logic                misaligned;
  logic [STRB-1:0]     req_mask;
  logic [DATA_W-1:0]   req_data;
  logic [2:0]          req_opcode;
  logic [DATA_W-1:0]   load_data;
  logic                d_err;

  always_comb begin : req_decode
    int unsigned nb;
    logic [15:0] span;
    nb = 32'd1 << req_size;
    if (nb > STRB) nb = STRB;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    span     = 16'((32'd1 << nb) - 32'd1);
    req_mask = STRB'(span << req_addr[OFF-1:0]);
    // Each lane copies the store byte at the same position within its access-sized slot.
    req_data = '0;
    for (int unsigned i = 0; i < STRB; i++) begin
      for (int unsigned j = 0; j < STRB; j++) begin
        if (j == (i & (nb - 32'd1))) req_data[8*i +: 8] = req_wdata[8*j +: 8];
      end
    end
    if (!req_we)        req_opcode = 3'd4;
    else if (&req_mask) req_opcode = 3'd0;
    else                req_opcode = 3'd1;
  end

  always_comb begin : rsp_decode
    logic [DATA_W-1:0] shifted;
    int unsigned       nbits;
    logic              sign_bit;
    shifted  = d_data >> {a_address[OFF-1:0], 3'b000};
    nbits    = 32'd8 << a_size;
    sign_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i + 32'd1 == nbits) sign_bit = shifted[i] & ~uns_q;
    end
    load_data = shifted;
    if (nbits < DATA_W) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (i >= nbits) load_data[i] = sign_bit;
      end
    end
    d_err = d_error || (d_opcode != (we_q ? 3'd0 : 3'd1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      a_valid   <= 1'b0;
      a_opcode  <= 3'd4;
      a_size    <= 2'd0;
      a_address <= '0;
      a_mask    <= '0;
      a_data    <= '0;
      d_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
`ifdef TLUL_PORT_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          d_ready   <= IDLE_SINK;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            d_ready   <= 1'b0;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            if (misaligned) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= REQ;
              a_valid   <= 1'b1;
              a_opcode  <= req_opcode;
              a_size    <= req_size;
              a_address <= req_addr;
              a_mask    <= req_mask;
              a_data    <= req_data;
            end
          end
        end
        REQ: begin
          if (a_ready) begin
            a_valid <= 1'b0;
            d_ready <= 1'b1;
            state   <= WAIT;
`ifdef TLUL_PORT_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (d_valid) begin
            d_ready   <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= d_err;
            rsp_rdata <= (d_err || we_q) ? '0 : load_data;
          end
`ifdef TLUL_PORT_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            d_ready   <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          d_ready   <= IDLE_SINK;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
